// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: hold/shift/rotate/asr/load per cycle,
// plus a burst engine that repeats one op N times with busy/done.
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1,
    parameter int AW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_lo,
    input  logic             ser_in_hi,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             ser_out_hi,
    output logic             ser_out_lo,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_ROTL = 3'b011;
    localparam logic [2:0] M_ROTR = 3'b100;
    localparam logic [2:0] M_LOAD = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [2:0]       mode_q;
    logic [2:0]       op_mode;
    logic [AW-1:0]    cnt_q;
    logic [AW-1:0]    cnt_d;
    logic             busy_q;
    logic             done_q;

    // Next register value for the active op; a burst uses its latched mode.
    always_comb begin
        q_d     = q_q;
        op_mode = (state_q == S_RUN) ? mode_q : mode;
        case (op_mode)
            M_SHL:   q_d = {q_q[WIDTH-2:0], ser_in_lo};
            M_SHR:   q_d = {ser_in_hi, q_q[WIDTH-1:1]};
            M_ROTL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            M_ROTR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
            M_LOAD:  q_d = d;
            M_ASR:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            default: q_d = q_q;
        endcase
    end

    // Burst op count at start: hold does nothing, load runs once, else clamp.
    always_comb begin
        cnt_d = '0;
        case (mode)
            M_HOLD, 3'b111: cnt_d = '0;
            M_LOAD:         cnt_d = AW'(1);
            default:        cnt_d = (amt > AW'(WIDTH)) ? AW'(WIDTH) : amt;
        endcase
    end

    // Register, burst FSM and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            q_q     <= RST_VAL;
            mode_q  <= M_HOLD;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (set) begin
            state_q <= S_IDLE;
            q_q     <= SET_VAL;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (cnt_q != '0) begin
                        q_q   <= q_d;
                        cnt_q <= cnt_q - AW'(1);
                    end
                    if (cnt_q <= AW'(1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RUN;
                        mode_q  <= mode;
                        cnt_q   <= cnt_d;
                        busy_q  <= 1'b1;
                    end else if (en) begin
                        q_q <= q_d;
                    end
                end
            endcase
        end
    end

    assign q          = q_q;
    assign qbar       = ~q_q;
    assign ser_out_hi = q_q[WIDTH-1];
    assign ser_out_lo = q_q[0];
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed and random bench for shift_reg_univ (WIDTH=8).
// Outputs are compared against an arithmetic reference model.
module tb_shift_reg_univ;

    logic       clk;
    logic       reset;
    logic       set;
    logic       en;
    logic [2:0] mode;
    logic       start;
    logic [3:0] amt;
    logic [7:0] d;
    logic       ser_in_lo;
    logic       ser_in_hi;
    logic [7:0] q;
    logic [7:0] qbar;
    logic       ser_out_hi;
    logic       ser_out_lo;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    // Reference model state
    int m_q;
    int m_busy;
    int m_done;
    int m_mode;
    int m_ops;
    int m_cycles;

    shift_reg_univ #(
        .WIDTH(8),
        .RST_VAL(8'h00),
        .SET_VAL(8'hFF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .set(set),
        .en(en),
        .mode(mode),
        .start(start),
        .amt(amt),
        .d(d),
        .ser_in_lo(ser_in_lo),
        .ser_in_hi(ser_in_hi),
        .q(q),
        .qbar(qbar),
        .ser_out_hi(ser_out_hi),
        .ser_out_lo(ser_out_lo),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_op(int m, int v);
        int r;
        case (m)
            1: r = (v * 2 + int'(ser_in_lo)) % 256;
            2: r = v / 2 + int'(ser_in_hi) * 128;
            3: r = (v * 2) % 256 + v / 128;
            4: r = v / 2 + (v % 2) * 128;
            5: r = int'(d);
            6: r = v / 2 + ((v >= 128) ? 128 : 0);
            default: r = v;
        endcase
        return r;
    endfunction

    task automatic model_edge();
        int n;
        if (set) begin
            m_q = 255;
            m_busy = 0;
            m_done = 0;
        end else if (m_busy != 0) begin
            if (m_ops > 0) begin
                m_q = ref_op(m_mode, m_q);
                m_ops--;
            end
            m_cycles--;
            m_done = (m_cycles == 0) ? 1 : 0;
            m_busy = (m_cycles == 0) ? 0 : 1;
        end else if (start) begin
            m_mode = int'(mode);
            if (m_mode == 0 || m_mode == 7) n = 0;
            else if (m_mode == 5) n = 1;
            else n = (int'(amt) > 8) ? 8 : int'(amt);
            m_ops = n;
            m_cycles = (n == 0) ? 1 : n;
            m_busy = 1;
            m_done = 0;
        end else begin
            m_done = 0;
            if (en) m_q = ref_op(int'(mode), m_q);
        end
    endtask

    task automatic model_reset();
        m_q = 0;
        m_busy = 0;
        m_done = 0;
        m_ops = 0;
        m_cycles = 0;
    endtask

    task automatic check(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("q", int'(q), m_q);
        check("qbar", int'(qbar), 255 - m_q);
        check("ser_hi", int'(ser_out_hi), m_q / 128);
        check("ser_lo", int'(ser_out_lo), m_q % 2);
        check("busy", int'(busy), m_busy);
        check("done", int'(done), m_done);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_in();
        set = 0;
        en = 0;
        start = 0;
        mode = 3'b000;
    endtask

    task automatic do_load(logic [7:0] v);
        idle_in();
        en = 1;
        mode = 3'b101;
        d = v;
        tick();
        en = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1;
        set = 0;
        en = 0;
        mode = 0;
        start = 0;
        amt = 0;
        d = 0;
        ser_in_lo = 0;
        ser_in_hi = 0;
        model_reset();
        m_mode = 0;
        #12;
        check_all();
        check("rst_q", int'(q), 0);
        @(negedge clk);
        reset = 0;

        // 1. immediate ops
        do_load(8'h81);
        en = 1;
        mode = 3'b001;
        ser_in_lo = 1;
        tick();
        check("shl", int'(q), 8'h03);
        mode = 3'b010;
        ser_in_hi = 0;
        tick();
        check("shr", int'(q), 8'h01);
        do_load(8'h80);
        en = 1;
        mode = 3'b110;
        ser_in_hi = 1;
        tick();
        check("asr", int'(q), 8'hC0);

        // 2. rotr burst of 4
        do_load(8'hA5);
        start = 1;
        mode = 3'b100;
        amt = 4;
        tick();
        idle_in();
        check("busy_e0", int'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("busy_run", int'(busy), 1);
        end
        tick();
        check("rotr4", int'(q), 8'h5A);
        check("done4", int'(done), 1);
        tick();
        check("done_clr", int'(done), 0);

        // 3. amt=0, then back-to-back clamped bursts
        do_load(8'h3C);
        start = 1;
        mode = 3'b011;
        amt = 0;
        tick();
        start = 0;
        tick();
        check("amt0_done", int'(done), 1);
        check("amt0_q", int'(q), 8'h3C);
        start = 1;
        amt = 12;
        tick();
        start = 0;
        repeat (8) tick();
        check("rotl12", int'(q), 8'h3C);
        check("rotl12_d", int'(done), 1);
        start = 1;
        mode = 3'b001;
        ser_in_lo = 0;
        tick();
        idle_in();
        repeat (8) tick();
        check("shl12", int'(q), 8'h00);

        // 4. async reset mid-burst
        do_load(8'hA5);
        start = 1;
        mode = 3'b011;
        amt = 3;
        tick();
        idle_in();
        tick();
        check("rotl1", int'(q), 8'h4B);
        #2;
        reset = 1;
        #1;
        model_reset();
        check_all();
        check("arst_busy", int'(busy), 0);
        #1;
        reset = 0;
        repeat (2) tick();

        // 5. set priority, set aborting burst, start while busy
        set = 1;
        en = 1;
        mode = 3'b101;
        d = 8'h3C;
        tick();
        check("set_q", int'(q), 8'hFF);
        do_load(8'h12);
        start = 1;
        mode = 3'b100;
        amt = 5;
        tick();
        idle_in();
        tick();
        set = 1;
        tick();
        set = 0;
        check("set_abort", int'(busy), 0);
        repeat (3) tick();
        check("no_done", int'(done), 0);
        start = 1;
        mode = 3'b011;
        amt = 6;
        tick();
        start = 1;
        en = 1;
        mode = 3'b101;
        d = 8'h00;
        repeat (6) tick();
        check("busy_ign", int'(q), 8'hFF);
        idle_in();
        repeat (2) tick();

        // 6. random sweep
        for (int i = 0; i < 600; i++) begin
            set = ($urandom_range(0, 31) == 0);
            en = $urandom_range(0, 1) == 1;
            start = ($urandom_range(0, 5) == 0);
            mode = 3'($urandom_range(0, 7));
            amt = 4'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            ser_in_lo = $urandom_range(0, 1) == 1;
            ser_in_hi = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
